// File: rtl/store_buffer_mc.sv
// In-order store buffer: speculative allocation, ROB-driven commit, in-order drain and byte-lane load forwarding.
// Define SB_LOAD_FWD_EN to build the forwarding merge network; otherwise any address match signals fwd_conflict_o.
module store_buffer_mc #(
  parameter int unsigned SB_SIZE  = 8,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  input  logic                           push_valid_i,
  output logic                           push_ready_o,
  input  logic [ADDR_W-1:0]              push_addr_i,
  input  logic [DATA_W-1:0]              push_data_i,
  input  logic [DATA_W/8-1:0]            push_strb_i,
  input  logic [$clog2(COMMIT_W+1)-1:0]  commit_num_i,
  output logic                           drain_valid_o,
  input  logic                           drain_ready_i,
  output logic [ADDR_W-1:0]              drain_addr_o,
  output logic [DATA_W-1:0]              drain_data_o,
  output logic [DATA_W/8-1:0]            drain_strb_o,
  input  logic [ADDR_W-1:0]              ld_addr_i,
  input  logic [DATA_W/8-1:0]            ld_strb_i,
  output logic [DATA_W-1:0]              fwd_data_o,
  output logic [DATA_W/8-1:0]            fwd_strb_o,
  output logic                           fwd_conflict_o,
  output logic [$clog2(SB_SIZE):0]       sb_cnt_o,
  output logic [$clog2(SB_SIZE):0]       uncommit_cnt_o,
  output logic                           empty_o
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(SB_SIZE);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam logic [CNT_W-1:0] SB_FULL = CNT_W'(SB_SIZE);

  logic [ADDR_W-1:0] addr_q [SB_SIZE];
  logic [DATA_W-1:0] data_q [SB_SIZE];
  logic [STRB_W-1:0] strb_q [SB_SIZE];
  logic [SB_SIZE-1:0] valid_q, valid_d, commit_q, commit_d;

  logic [PTR_W-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d, uncommit_cnt_q, uncommit_cnt_d;
  logic             push_ready_q, push_ready_d;

  logic             push, pop;
  logic [31:0]      eff_req;
  logic [CNT_W-1:0] eff;
  logic [SB_SIZE-1:0] hit;

  assign push_ready_o   = push_ready_q;
  assign drain_valid_o  = valid_q[tail_q] & commit_q[tail_q];
  assign drain_addr_o   = addr_q[tail_q];
  assign drain_data_o   = data_q[tail_q];
  assign drain_strb_o   = strb_q[tail_q];
  assign sb_cnt_o       = sb_cnt_q;
  assign uncommit_cnt_o = uncommit_cnt_q;
  assign empty_o        = (sb_cnt_q == '0);

  assign push = push_valid_i & push_ready_q & ~flush_i;
  assign pop  = drain_valid_o & drain_ready_i;

  always_comb begin
    eff_req = 32'(commit_num_i);
    if (eff_req > COMMIT_W) eff_req = COMMIT_W;
    if (eff_req > 32'(uncommit_cnt_q)) eff_req = 32'(uncommit_cnt_q);
    eff = CNT_W'(eff_req);
  end

  // Entry flags: commit, pop, flush-discard and push touch disjoint slots, so order here is free.
  always_comb begin
    valid_d  = valid_q;
    commit_d = commit_q;
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      if (CNT_W'(i) < eff) commit_d[PTR_W'(cmt_q + i)] = 1'b1;
    end
    if (pop) begin
      valid_d[tail_q]  = 1'b0;
      commit_d[tail_q] = 1'b0;
    end
    if (flush_i) begin
      for (int unsigned k = 0; k < SB_SIZE; k++) begin
        if (CNT_W'(k) >= eff && CNT_W'(k) < uncommit_cnt_q) begin
          valid_d[PTR_W'(cmt_q + k)]  = 1'b0;
          commit_d[PTR_W'(cmt_q + k)] = 1'b0;
        end
      end
    end
    if (push) begin
      valid_d[head_q]  = 1'b1;
      commit_d[head_q] = 1'b0;
    end
  end

  always_comb begin
    cmt_d  = PTR_W'(cmt_q + eff);
    tail_d = tail_q + PTR_W'(pop);
    if (flush_i) begin
      head_d         = PTR_W'(cmt_q + eff);
      sb_cnt_d       = sb_cnt_q - CNT_W'(pop) - uncommit_cnt_q + eff;
      uncommit_cnt_d = '0;
    end else begin
      head_d         = head_q + PTR_W'(push);
      sb_cnt_d       = sb_cnt_q + CNT_W'(push) - CNT_W'(pop);
      uncommit_cnt_d = uncommit_cnt_q + CNT_W'(push) - eff;
    end
    push_ready_d = (sb_cnt_d < SB_FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q         <= '0;
      cmt_q          <= '0;
      tail_q         <= '0;
      sb_cnt_q       <= '0;
      uncommit_cnt_q <= '0;
      push_ready_q   <= 1'b1;
      valid_q        <= '0;
      commit_q       <= '0;
      for (int unsigned e = 0; e < SB_SIZE; e++) begin
        addr_q[e] <= '0;
        data_q[e] <= '0;
        strb_q[e] <= '0;
      end
    end else begin
      head_q         <= head_d;
      cmt_q          <= cmt_d;
      tail_q         <= tail_d;
      sb_cnt_q       <= sb_cnt_d;
      uncommit_cnt_q <= uncommit_cnt_d;
      push_ready_q   <= push_ready_d;
      valid_q        <= valid_d;
      commit_q       <= commit_d;
      if (push) begin
        addr_q[head_q] <= push_addr_i;
        data_q[head_q] <= push_data_i;
        strb_q[head_q] <= push_strb_i;
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int unsigned e = 0; e < SB_SIZE; e++) begin
      hit[e] = valid_q[e]
             && (addr_q[e][ADDR_W-1:OFF_W] == ld_addr_i[ADDR_W-1:OFF_W])
             && (|(strb_q[e] & ld_strb_i));
    end
  end

  if (OFF_W > 0) begin : g_unused_lo
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr_i[OFF_W-1:0];
  end

`ifdef SB_LOAD_FWD_EN
  logic [DATA_W-1:0] fwd_data_c;
  logic [STRB_W-1:0] fwd_strb_c;
  logic [PTR_W-1:0]  scan_idx;

  // Oldest-to-youngest scan; later writes overwrite, so the youngest match owns each lane.
  always_comb begin
    fwd_data_c = '0;
    fwd_strb_c = '0;
    scan_idx   = '0;
    for (int unsigned k = 0; k < SB_SIZE; k++) begin
      scan_idx = PTR_W'(tail_q + k);
      if (hit[scan_idx]) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (strb_q[scan_idx][b] && ld_strb_i[b]) begin
            fwd_data_c[b*8 +: 8] = data_q[scan_idx][b*8 +: 8];
            fwd_strb_c[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_data_o     = fwd_data_c;
  assign fwd_strb_o     = fwd_strb_c;
  assign fwd_conflict_o = 1'b0;
`else
  assign fwd_data_o     = '0;
  assign fwd_strb_o     = '0;
  assign fwd_conflict_o = |hit;
`endif

endmodule

// File: tb/tb_store_buffer_mc.sv
// Scoreboard bench for store_buffer_mc: queue-level reference model plus a decoupled drain monitor.
module tb_store_buffer_mc;

  localparam int SB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i, push_valid_i, push_ready_o;
  logic [31:0] push_addr_i, push_data_i;
  logic [3:0]  push_strb_i;
  logic [1:0]  commit_num_i;
  logic        drain_valid_o, drain_ready_i;
  logic [31:0] drain_addr_o, drain_data_o;
  logic [3:0]  drain_strb_o;
  logic [31:0] ld_addr_i;
  logic [3:0]  ld_strb_i;
  logic [31:0] fwd_data_o;
  logic [3:0]  fwd_strb_o;
  logic        fwd_conflict_o;
  logic [3:0]  sb_cnt_o, uncommit_cnt_o;
  logic        empty_o;

  always #5 clk = ~clk;

  store_buffer_mc #(
    .SB_SIZE(8), .ADDR_W(32), .DATA_W(32), .COMMIT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_addr_i(push_addr_i), .push_data_i(push_data_i), .push_strb_i(push_strb_i),
    .commit_num_i(commit_num_i),
    .drain_valid_o(drain_valid_o), .drain_ready_i(drain_ready_i),
    .drain_addr_o(drain_addr_o), .drain_data_o(drain_data_o), .drain_strb_o(drain_strb_o),
    .ld_addr_i(ld_addr_i), .ld_strb_i(ld_strb_i),
    .fwd_data_o(fwd_data_o), .fwd_strb_o(fwd_strb_o), .fwd_conflict_o(fwd_conflict_o),
    .sb_cnt_o(sb_cnt_o), .uncommit_cnt_o(uncommit_cnt_o), .empty_o(empty_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          cmt;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  ent_t mq[$];     // buffer contents, oldest first
  exp_t exp_q[$];  // stores expected to reach the cache, in order

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Drain monitor: every handshake must deliver the oldest surviving store.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && drain_valid_o && drain_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("drain_unexpected", 64'(drain_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", 64'(drain_addr_o), 64'(e.addr));
          chk("drain_data", 64'(drain_data_o), 64'(e.data));
          chk("drain_strb", 64'(drain_strb_o), 64'(e.strb));
        end
      end
    end
  end

  task automatic cycle(input bit pv, input logic [31:0] pa, input logic [31:0] pd,
                       input logic [3:0] ps, input int cn, input bit fl, input bit dr,
                       input logic [31:0] la, input logic [3:0] ls);
    int cnt, unc, eff;
    bit ready, dv, conf, push, pop, m;
    logic [31:0] ed, mask;
    logic [3:0] es;
    @(negedge clk);
    push_valid_i  = pv;
    push_addr_i   = pa;
    push_data_i   = pd;
    push_strb_i   = ps;
    commit_num_i  = 2'(cn);
    flush_i       = fl;
    drain_ready_i = dr;
    ld_addr_i     = la;
    ld_strb_i     = ls;
    #2;
    cnt = mq.size();
    unc = 0;
    foreach (mq[i]) if (!mq[i].cmt) unc++;
    ready = (cnt < SB);
    dv    = (cnt > 0) && mq[0].cmt;
    chk("push_ready", 64'(push_ready_o), 64'(ready));
    chk("drain_valid", 64'(drain_valid_o), 64'(dv));
    chk("sb_cnt", 64'(sb_cnt_o), 64'(cnt));
    chk("uncommit_cnt", 64'(uncommit_cnt_o), 64'(unc));
    chk("empty", 64'(empty_o), 64'(cnt == 0));

    // Per lane: find the youngest store to this word that overlaps the load and writes the lane.
    ed = '0; es = '0; conf = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (ls[b]) begin
        for (int i = mq.size() - 1; i >= 0; i--) begin
          if ((mq[i].addr >> 2) == (la >> 2) && (mq[i].strb & ls) != 0 && mq[i].strb[b]) begin
            ed[8*b +: 8] = mq[i].data[8*b +: 8];
            es[b] = 1'b1;
            break;
          end
        end
      end
    end
    foreach (mq[i]) begin
      m = ((mq[i].addr >> 2) == (la >> 2)) && ((mq[i].strb & ls) != 0);
      if (m) conf = 1'b1;
    end
    mask = '0;
    for (int b = 0; b < 4; b++) if (es[b]) mask[8*b +: 8] = 8'hFF;
`ifdef SB_LOAD_FWD_EN
    chk("fwd_strb", 64'(fwd_strb_o), 64'(es));
    chk("fwd_data", 64'(fwd_data_o & mask), 64'(ed));
    chk("fwd_conflict", 64'(fwd_conflict_o), 64'(0));
`else
    chk("fwd_strb", 64'(fwd_strb_o), 64'(0));
    chk("fwd_data", 64'(fwd_data_o), 64'(0));
    chk("fwd_conflict", 64'(fwd_conflict_o), 64'(conf));
`endif

    push = pv && ready && !fl;
    eff  = (cn < unc) ? cn : unc;
    pop  = dv && dr;
    for (int i = 0; i < eff; i++) mq[cnt - unc + i].cmt = 1'b1;
    if (pop) void'(mq.pop_front());
    if (fl) begin
      repeat (unc - eff) begin
        void'(mq.pop_back());
        void'(exp_q.pop_back());
      end
    end
    if (push) begin
      mq.push_back('{pa, pd, ps, 1'b0});
      exp_q.push_back('{pa, pd, ps});
    end
  endtask

  task automatic idle(input int cn, input bit dr, input logic [31:0] la, input logic [3:0] ls);
    cycle(1'b0, '0, '0, '0, cn, 1'b0, dr, la, ls);
  endtask

  function automatic logic [31:0] rnd_addr();
    return 32'h200 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
  endfunction

  initial begin
    rst_n = 1'b0;
    flush_i = 1'b0; push_valid_i = 1'b0; push_addr_i = '0; push_data_i = '0;
    push_strb_i = '0; commit_num_i = '0; drain_ready_i = 1'b0; ld_addr_i = '0; ld_strb_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state, then fill to capacity without commits; the ninth push must be refused.
    idle(0, 1'b1, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++)
      cycle(1'b1, 32'h400 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 4'hF, 0, 1'b0, 1'b0, 32'h400, 4'hF);
    idle(0, 1'b1, 32'h400, 4'hF);
    cycle(1'b0, '0, '0, '0, 0, 1'b1, 1'b1, 32'h0, 4'h0);
    idle(0, 1'b1, 32'h400, 4'hF);

    // Single store through commit and drain.
    cycle(1'b1, 32'h100, 32'h1122_3344, 4'hF, 0, 1'b0, 1'b1, 32'h100, 4'hF);
    idle(1, 1'b1, 32'h100, 4'hF);
    idle(0, 1'b1, 32'h100, 4'hF);
    idle(0, 1'b1, 32'h100, 4'hF);

    // Four stores, two committed, flush committing one more: three survive and drain.
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'h300 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0, 1'b0, 1'b0, 32'h0, 4'h0);
    idle(2, 1'b0, 32'h300, 4'hF);
    cycle(1'b0, '0, '0, '0, 1, 1'b1, 1'b0, 32'h30C, 4'hF);
    for (int i = 0; i < 5; i++) idle(0, 1'b1, 32'h30C, 4'hF);

    // Overlapping stores to one word: lane-wise youngest wins, conflict clears after drain.
    cycle(1'b1, 32'h200, 32'h0000_AAAA, 4'h3, 0, 1'b0, 1'b0, 32'h200, 4'hF);
    cycle(1'b1, 32'h200, 32'h0000_BB00, 4'h2, 0, 1'b0, 1'b0, 32'h200, 4'hF);
    idle(0, 1'b0, 32'h200, 4'hF);
    idle(2, 1'b0, 32'h200, 4'hF);
    idle(0, 1'b1, 32'h200, 4'hF);
    idle(0, 1'b1, 32'h200, 4'hF);
    idle(0, 1'b1, 32'h200, 4'hF);

    // Pointer wrap: continuous pushes, commit bursts of two, drain ready toggling.
    for (int i = 0; i < 24; i++)
      cycle(1'b1, 32'h500 + 32'(i * 4), $urandom, 4'(1 + $urandom_range(0, 14)),
            (i % 2 == 0) ? 2 : 0, 1'b0, (i % 2 == 1), 32'h500, 4'hF);

    // Randomized mix of everything, including occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rnd_addr(), $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2), $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
            rnd_addr(), 4'($urandom_range(0, 15)));

    // Bounded drain-out to empty.
    for (int i = 0; i < 20; i++) idle(2, 1'b1, rnd_addr(), 4'hF);
    chk("final_empty", 64'(empty_o), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
